// File: rtl/riscv_pipe_pkg.sv
// Shared fetch/decode pipeline types: the queue entry layout and the bubble encoding.
package riscv_pipe_pkg;
  localparam int FQ_ADDR_W = 64;
  localparam int FQ_INST_W = 32;

  // An all-zero instruction word from fetch is a bubble, not a real instruction.
  localparam logic [31:0] NOP_WORD = 32'h0;

  typedef struct packed {
    logic [FQ_ADDR_W-1:0] pcplus1;
    logic [FQ_INST_W-1:0] instr;
  } fq_entry_t;
endpackage

// File: rtl/fetch_inst_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc+4, instruction} entries.
// Backpressure to fetch comes from registered occupancy only; flush empties everything.
module fetch_inst_queue
  import riscv_pipe_pkg::*;
#(
  parameter int ADDRESS_WIDTH     = FQ_ADDR_W,
  parameter int INSTRUCTION_WIDTH = FQ_INST_W,
  parameter int DEPTH             = 4,
  localparam int CNT_W            = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_fetch_valid,
  input  logic [ADDRESS_WIDTH-1:0]     in_pcplus1,
  input  logic [INSTRUCTION_WIDTH-1:0] in_instruction_bits,
  output logic                         out_fetch_enable,
  input  logic                         in_flush,
  output logic                         out_dec_valid,
  output logic [ADDRESS_WIDTH-1:0]     out_dec_pcplus1,
  output logic [INSTRUCTION_WIDTH-1:0] out_dec_instruction,
  input  logic                         in_dec_ready,
  output logic [CNT_W-1:0]             out_count,
  output logic [31:0]                  out_drop_count
);
  localparam int PTR_W = $clog2(DEPTH);

  fq_entry_t         mem_q [DEPTH];
  fq_entry_t         mem_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [31:0]       drop_cnt_q, drop_cnt_d;

  logic full, empty, is_nop, accept, enq, deq, bubble;
  fq_entry_t head;

  always_comb begin
    full   = (count_q == CNT_W'(DEPTH));
    empty  = (count_q == '0);
    is_nop = (in_instruction_bits == INSTRUCTION_WIDTH'(NOP_WORD));
    // A word is only taken when fetch saw enable=1 and no flush kills it.
    accept = in_fetch_valid & ~full & ~in_flush;
    enq    = accept & ~is_nop;
    bubble = accept & is_nop;
    deq    = ~empty & in_dec_ready & ~in_flush;

    mem_d      = mem_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    drop_cnt_d = drop_cnt_q;

    if (in_flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (enq) begin
        mem_d[wr_ptr_q].pcplus1 = in_pcplus1;
        mem_d[wr_ptr_q].instr   = in_instruction_bits;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end

    if (bubble && (drop_cnt_q != 32'hFFFF_FFFF)) drop_cnt_d = drop_cnt_q + 32'd1;

    // Outputs come straight from registered state, forced to 0 while reset is held.
    head                = mem_q[rd_ptr_q];
    out_fetch_enable    = ~reset & ~full;
    out_dec_valid       = ~reset & ~empty;
    out_dec_pcplus1     = out_dec_valid ? head.pcplus1 : '0;
    out_dec_instruction = out_dec_valid ? head.instr   : '0;
    out_count           = reset ? '0 : count_q;
    out_drop_count      = reset ? '0 : drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      mem_q      <= mem_d;
    end
  end
endmodule

// File: tb/tb_fetch_inst_queue.sv
// Randomized plus directed bench for fetch_inst_queue against a queue-based reference model.
module tb_fetch_inst_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic        clk = 0;
  logic        reset = 1;
  logic        in_fetch_valid = 0;
  logic [63:0] in_pcplus1 = '0;
  logic [31:0] in_instruction_bits = '0;
  logic        out_fetch_enable;
  logic        in_flush = 0;
  logic        out_dec_valid;
  logic [63:0] out_dec_pcplus1;
  logic [31:0] out_dec_instruction;
  logic        in_dec_ready = 0;
  logic [CNT_W-1:0] out_count;
  logic [31:0] out_drop_count;

  fetch_inst_queue #(.ADDRESS_WIDTH(64), .INSTRUCTION_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_fetch_valid(in_fetch_valid), .in_pcplus1(in_pcplus1),
    .in_instruction_bits(in_instruction_bits), .out_fetch_enable(out_fetch_enable),
    .in_flush(in_flush), .out_dec_valid(out_dec_valid), .out_dec_pcplus1(out_dec_pcplus1),
    .out_dec_instruction(out_dec_instruction), .in_dec_ready(in_dec_ready),
    .out_count(out_count), .out_drop_count(out_drop_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of entries plus a bubble counter.
  typedef struct { logic [63:0] pc; logic [31:0] ins; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_drop = '0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_drop = '0;
    end else if (in_flush) begin
      mq.delete();
    end else begin
      bit can_take, pop;
      ent_t e;
      can_take = in_fetch_valid && (mq.size() < DEPTH);
      pop      = in_dec_ready && (mq.size() > 0);
      if (can_take && in_instruction_bits == 0 && m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
      if (pop) void'(mq.pop_front());
      if (can_take && in_instruction_bits != 0) begin
        e.pc = in_pcplus1; e.ins = in_instruction_bits;
        mq.push_back(e);
      end
    end
  end

  // Single compare point, half a cycle away from the active edge.
  always @(negedge clk) begin
    logic [63:0] e_pc;
    logic [31:0] e_ins;
    bit e_v;
    e_v   = !reset && mq.size() > 0;
    e_pc  = e_v ? mq[0].pc  : 64'h0;
    e_ins = e_v ? mq[0].ins : 32'h0;
    chk("dec_valid", 64'(out_dec_valid), 64'(e_v));
    chk("dec_pc",    out_dec_pcplus1, e_pc);
    chk("dec_instr", 64'(out_dec_instruction), 64'(e_ins));
    chk("count",     64'(out_count), reset ? 64'h0 : 64'(mq.size()));
    chk("fetch_en",  64'(out_fetch_enable), 64'(!reset && mq.size() < DEPTH));
    chk("drop_cnt",  64'(out_drop_count), reset ? 64'h0 : 64'(m_drop));
  end

  logic [63:0] pcv = 64'h1000;

  // Inputs change 2 time units after a posedge and are consumed at the following posedge.
  task automatic drive(input bit v, input logic [31:0] ins, input bit rdy,
                       input bit fl, input bit rst);
    @(posedge clk); #2;
    in_fetch_valid      = v;
    in_instruction_bits = ins;
    in_pcplus1          = pcv;
    in_dec_ready        = rdy;
    in_flush            = fl;
    reset               = rst;
    if (v) pcv = pcv + 64'd4;
  endtask

  // Let the last driven cycle take effect, then sample just after the edge.
  task automatic settle();
    drive(0, 32'h0, 0, 0, 0);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    #1;
    chk("rst_fetch_en", 64'(out_fetch_enable), 64'h0);
    chk("rst_count", 64'(out_count), 64'h0);

    // 1) three words, decode stalled, then drain in order
    settle();
    chk("t1_fetch_en_after_rst", 64'(out_fetch_enable), 64'h1);
    drive(1, 32'h0000_0013, 0, 0, 0);
    drive(1, 32'h0050_0093, 0, 0, 0);
    drive(1, 32'h00A0_0113, 0, 0, 0);
    settle();
    chk("t1_count", 64'(out_count), 64'd3);
    chk("t1_head", 64'(out_dec_instruction), 64'h13);
    chk("t1_fetch_en", 64'(out_fetch_enable), 64'h1);
    drive(0, 0, 1, 0, 0);
    settle();
    chk("t1_head2", 64'(out_dec_instruction), 64'h0050_0093);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    settle();
    chk("t1_drained", 64'(out_count), 64'd0);

    // 2) five back-to-back pushes into a depth-4 queue
    for (int i = 1; i <= 5; i++) drive(1, 32'h100 + 32'(i), 0, 0, 0);
    settle();
    chk("t2_count", 64'(out_count), 64'd4);
    chk("t2_fetch_en", 64'(out_fetch_enable), 64'h0);
    chk("t2_head", 64'(out_dec_instruction), 64'h101);

    // 3) full with push and pop together: pop only
    drive(1, 32'h0BAD_0001, 1, 0, 0);
    settle();
    chk("t3_count", 64'(out_count), 64'd3);
    chk("t3_head", 64'(out_dec_instruction), 64'h102);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0);
    settle();
    chk("t3_drained", 64'(out_count), 64'd0);

    // 4) flush at count=2 with fetch and decode handshakes in the same cycle
    drive(1, 32'h201, 0, 0, 0);
    drive(1, 32'h202, 0, 0, 0);
    drive(1, 32'h203, 1, 1, 0);
    settle();
    chk("t4_count", 64'(out_count), 64'd0);
    chk("t4_valid", 64'(out_dec_valid), 64'h0);
    chk("t4_fetch_en", 64'(out_fetch_enable), 64'h1);

    // 5) a bubble then a real word
    drive(1, 32'h0, 0, 0, 0);
    drive(1, 32'h13, 0, 0, 0);
    settle();
    chk("t5_count", 64'(out_count), 64'd1);
    chk("t5_head", 64'(out_dec_instruction), 64'h13);
    chk("t5_drop", 64'(out_drop_count), 64'd1);

    // 6) reset with entries present
    drive(1, 32'h301, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    #1;
    chk("t6_rst_valid", 64'(out_dec_valid), 64'h0);
    chk("t6_rst_count", 64'(out_count), 64'd0);
    chk("t6_rst_drop", 64'(out_drop_count), 64'd0);
    chk("t6_rst_instr", 64'(out_dec_instruction), 64'h0);
    settle();
    chk("t6_fetch_en", 64'(out_fetch_enable), 64'h1);
    chk("t6_count", 64'(out_count), 64'd0);

    // Random traffic, checked every cycle by the compare process
    for (int i = 0; i < 1000; i++) begin
      bit v, r, f, rs;
      logic [31:0] w;
      v  = ($urandom_range(0, 99) < 60);
      r  = ($urandom_range(0, 99) < 45);
      f  = ($urandom_range(0, 99) < 3);
      rs = ($urandom_range(0, 199) == 0);
      w  = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
      drive(v, w, r, f, rs);
    end
    settle();
    @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
